// File: rtl/ddr_2_mrmac.sv
`timescale 1ns/1ps
// ddr_2_mrmac: AXI4 read master that fetches Ethernet frames from DDR and
// replays them as a wide AXI-Stream toward the MRMAC TX path.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_*                frame command (address, byte length, valid/ready)
//   sts_valid/sts_error  one-cycle completion pulse per command, error flag
//   m_axi_ar*            AXI4 read address channel (one INCR burst per frame)
//   m_axi_r*             AXI4 read data channel
//   m_axis_*             AXI-Stream frame output (tkeep on the last beat,
//                        tuser=1 on the tlast beat marks a corrupt frame)
module ddr_2_mrmac #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [15:0]             cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,

    output logic                    sts_valid,
    output logic                    sts_error,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int unsigned KEEP_W     = BEAT_BYTES;
    localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam logic [15:0] MIN_LEN    = 16'd64;
    localparam logic [15:0] MAX_LEN    = 16'd1500;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_W-1:0]     keep;
        logic                  last;
        logic                  user;
    } beat_t;

    // Control state
    state_t             state_q, state_d;
    logic [KEEP_W-1:0]  keep_last_q, keep_last_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic               err_acc_q, err_acc_d;
    logic               drain_q, drain_d;

    // Next values of registered outputs
    logic                  cmd_ready_d;
    logic                  sts_valid_d;
    logic                  sts_error_d;
    logic                  arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_d;
    logic [7:0]            arlen_d;
    logic                  rready_d;

    // FIFO
    beat_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   free_entries;
    logic               push, pop;
    beat_t              push_beat;
    beat_t              head;

    // Command decode
    logic               cmd_fire;
    logic               len_ok;
    logic [7:0]         cmd_beats;
    logic [OFF_W-1:0]   cmd_rem;
    logic [KEEP_W-1:0]  cmd_keep;

    // R beat qualifiers
    logic               r_fire;
    logic               rresp_err;
    logic               is_last;
    logic               err_now;

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = 3'(OFF_W);
    assign m_axi_arburst = 2'b01;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign len_ok    = (cmd_len >= MIN_LEN) && (cmd_len <= MAX_LEN);
    assign cmd_beats = 8'((17'(cmd_len) + 17'(BEAT_BYTES - 1)) >> OFF_W);
    assign cmd_rem   = cmd_len[OFF_W-1:0];
    assign cmd_keep  = (cmd_rem == '0) ? '1
                     : ((KEEP_W'(1) << cmd_rem) - KEEP_W'(1));

    assign r_fire    = m_axi_rvalid && m_axi_rready;
    assign rresp_err = (m_axi_rresp >= 2'b10);

    // Pops in the current cycle count as free space for the reservation
    assign pop          = (count_q != '0) && m_axis_tready;
    assign free_entries = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            keep_last_q   <= '0;
            beat_cnt_q    <= '0;
            err_acc_q     <= 1'b0;
            drain_q       <= 1'b0;
            cmd_ready     <= 1'b0;
            sts_valid     <= 1'b0;
            sts_error     <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_rready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            keep_last_q   <= keep_last_d;
            beat_cnt_q    <= beat_cnt_d;
            err_acc_q     <= err_acc_d;
            drain_q       <= drain_d;
            cmd_ready     <= cmd_ready_d;
            sts_valid     <= sts_valid_d;
            sts_error     <= sts_error_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arlen   <= arlen_d;
            m_axi_rready  <= rready_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        keep_last_d = keep_last_q;
        beat_cnt_d  = beat_cnt_q;
        err_acc_d   = err_acc_q;
        drain_d     = drain_q;
        sts_valid_d = 1'b0;
        sts_error_d = 1'b0;
        arvalid_d   = m_axi_arvalid;
        araddr_d    = m_axi_araddr;
        arlen_d     = m_axi_arlen;
        push        = 1'b0;
        is_last     = 1'b0;
        err_now     = 1'b0;
        push_beat.data = m_axi_rdata;
        push_beat.keep = '1;
        push_beat.last = 1'b0;
        push_beat.user = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Swallow surplus R beats of the previous burst up to rlast
                if (drain_q && r_fire && m_axi_rlast) begin
                    drain_d = 1'b0;
                end
                if (cmd_fire) begin
                    if (!len_ok) begin
                        sts_valid_d = 1'b1;
                        sts_error_d = 1'b1;
                    end else begin
                        araddr_d    = cmd_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                        arlen_d     = cmd_beats - 8'd1;
                        keep_last_d = cmd_keep;
                        beat_cnt_d  = '0;
                        err_acc_d   = 1'b0;
                        state_d     = S_REQ;
                    end
                end
            end

            S_REQ: begin
                // Issue the burst only when the whole frame fits in the FIFO
                if (m_axi_arvalid) begin
                    if (m_axi_arready) begin
                        arvalid_d = 1'b0;
                        state_d   = S_DATA;
                    end
                end else if (16'(free_entries) > 16'(m_axi_arlen)) begin
                    arvalid_d = 1'b1;
                end
            end

            S_DATA: begin
                if (r_fire) begin
                    push    = 1'b1;
                    is_last = (beat_cnt_q == m_axi_arlen);
                    err_now = err_acc_q || rresp_err || (m_axi_rlast != is_last);
                    if (is_last) begin
                        push_beat.keep = keep_last_q;
                        push_beat.last = 1'b1;
                        push_beat.user = err_now;
                        sts_valid_d    = 1'b1;
                        sts_error_d    = err_now;
                        err_acc_d      = 1'b0;
                        drain_d        = !m_axi_rlast;
                        state_d        = S_IDLE;
                    end else begin
                        err_acc_d  = err_now;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE) && !drain_d;
        rready_d    = (state_d == S_DATA) || drain_d;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; reservation guarantees the write slot is free
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_beat;
        end
    end

    // First-word-fall-through head; payload forced to zero while empty
    assign head          = fifo_mem[rd_ptr_q];
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? head.keep : '0;
    assign m_axis_tlast  = m_axis_tvalid && head.last;
    assign m_axis_tuser  = m_axis_tvalid && head.user;

endmodule

// File: tb/tb_ddr_2_mrmac.sv
`timescale 1ns/1ps
// Directed self-checking bench for ddr_2_mrmac: an AXI read responder and an
// AXIS/status collector run alongside one linear stimulus sequence.
module tb_ddr_2_mrmac;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 512;
    localparam int unsigned IW = 4;
    localparam int unsigned KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          sts_valid;
    logic          sts_error;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    always #5 clk = ~clk;

    ddr_2_mrmac dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .sts_valid     (sts_valid),
        .sts_error     (sts_error),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } axis_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [IW-1:0] id;
        int            seen;
    } ar_t;

    axis_t axis_q[$];
    logic  sts_q[$];
    ar_t   ar_q[$];

    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_axis_seen = 0;
    logic  tready_en;
    logic  ar_ready_en;
    int    err_beat;

    // Responder state
    logic          ar_pend  = 1'b0;
    logic          r_pend   = 1'b0;
    logic          r_active = 1'b0;
    logic [AW-1:0] r_base   = '0;
    int            r_total  = 0;
    int            r_idx    = 0;

    // Collector state
    logic  ax_pend = 1'b0;
    axis_t ax_cap  = '0;

    localparam logic [KW-1:0] KEEP_ALL  = '1;
    localparam logic [KW-1:0] KEEP_1500 = 64'h0000_0000_0FFF_FFFF;

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] base, input int idx);
        logic [31:0] i32;
        i32 = 32'(idx);
        return {8{base, i32}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic axis_t pop_axis();
        if (axis_q.size() != 0) return axis_q.pop_front();
        return '0;
    endfunction

    function automatic ar_t pop_ar();
        if (ar_q.size() != 0) return ar_q.pop_front();
        return '0;
    endfunction

    function automatic logic pop_sts();
        if (sts_q.size() != 0) return sts_q.pop_front();
        return 1'bx;
    endfunction

    task automatic send_cmd(input logic [AW-1:0] a, input logic [15:0] l);
        int i;
        i = 0;
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("cmd_accept", DW'(cmd_ready), DW'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_q(input int n_axis, input int n_sts, input int budget);
        int i;
        i = 0;
        while ((axis_q.size() < n_axis || sts_q.size() < n_sts) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("axis_count", DW'(axis_q.size()), DW'(n_axis));
        chk("sts_count", DW'(sts_q.size()), DW'(n_sts));
    endtask

    // AXI read responder: one burst at a time, incrementing data pattern
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                r_active      = 1'b0;
                ar_pend       = 1'b0;
                r_pend        = 1'b0;
            end else begin
                if (ar_pend) begin
                    r_active = 1'b1;
                    r_idx    = 0;
                end
                if (r_pend) begin
                    r_idx++;
                    if (r_idx == r_total) r_active = 1'b0;
                end
                m_axi_arready = ar_ready_en && !r_active;
                m_axi_rvalid  = r_active;
                if (r_active) begin
                    m_axi_rdata = exp_data(r_base, r_idx);
                    m_axi_rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
                    m_axi_rlast = (r_idx == r_total - 1);
                end else begin
                    m_axi_rresp = 2'b00;
                    m_axi_rlast = 1'b0;
                end
                ar_pend = m_axi_arvalid && m_axi_arready;
                if (ar_pend) begin
                    r_base  = m_axi_araddr;
                    r_total = int'(m_axi_arlen) + 1;
                    ar_q.push_back('{m_axi_araddr, m_axi_arlen, m_axi_arsize,
                                     m_axi_arburst, m_axi_arid, n_axis_seen});
                end
                r_pend = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    // AXIS sink and status collector
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ax_pend       = 1'b0;
                m_axis_tready = 1'b0;
            end else begin
                if (ax_pend) begin
                    axis_q.push_back(ax_cap);
                    n_axis_seen++;
                end
                if (sts_valid) sts_q.push_back(sts_error);
                m_axis_tready = tready_en;
                ax_pend = m_axis_tvalid && m_axis_tready;
                ax_cap  = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_t b;
        ar_t   a;
        ar_t   a2;
        int    seen0;
        int    i;
        logic  s;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        tready_en   = 1'b0;
        ar_ready_en = 1'b0;
        err_beat    = -1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_cmd_ready", DW'(cmd_ready), DW'(0));
        chk("rst_sts_valid", DW'(sts_valid), DW'(0));
        chk("rst_sts_error", DW'(sts_error), DW'(0));
        chk("rst_arvalid",   DW'(m_axi_arvalid), DW'(0));
        chk("rst_araddr",    DW'(m_axi_araddr), DW'(0));
        chk("rst_arlen",     DW'(m_axi_arlen), DW'(0));
        chk("rst_rready",    DW'(m_axi_rready), DW'(0));
        chk("rst_tvalid",    DW'(m_axis_tvalid), DW'(0));
        chk("rst_tlast",     DW'(m_axis_tlast), DW'(0));
        chk("rst_tuser",     DW'(m_axis_tuser), DW'(0));
        chk("rst_tkeep",     DW'(m_axis_tkeep), DW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", DW'(cmd_ready), DW'(1));

        // Single-beat frame
        ar_ready_en = 1'b1;
        tready_en   = 1'b1;
        send_cmd(32'h1000_0040, 16'd64);
        wait_q(1, 1, 100);
        a = pop_ar();
        chk("t1_araddr",  DW'(a.addr), DW'(32'h1000_0040));
        chk("t1_arlen",   DW'(a.len), DW'(0));
        chk("t1_arsize",  DW'(a.size), DW'(6));
        chk("t1_arburst", DW'(a.burst), DW'(1));
        chk("t1_arid",    DW'(a.id), DW'(0));
        b = pop_axis();
        chk("t1_tdata", b.data, exp_data(32'h1000_0040, 0));
        chk("t1_tlast", DW'(b.last), DW'(1));
        chk("t1_tkeep", DW'(b.keep), DW'(KEEP_ALL));
        chk("t1_tuser", DW'(b.user), DW'(0));
        s = pop_sts();
        chk("t1_sts_error", DW'(s), DW'(0));

        // Maximum frame, partial last beat
        send_cmd(32'h2000_0000, 16'd1500);
        wait_q(24, 1, 300);
        a = pop_ar();
        chk("t2_araddr", DW'(a.addr), DW'(32'h2000_0000));
        chk("t2_arlen",  DW'(a.len), DW'(23));
        for (i = 0; i < 24; i++) begin
            b = pop_axis();
            chk("t2_tdata", b.data, exp_data(32'h2000_0000, i));
            chk("t2_tlast", DW'(b.last), DW'(i == 23));
            chk("t2_tkeep", DW'(b.keep), DW'((i == 23) ? KEEP_1500 : KEEP_ALL));
        end
        s = pop_sts();
        chk("t2_sts_error", DW'(s), DW'(0));

        // Rejected lengths
        send_cmd(32'h2000_0000, 16'd63);
        send_cmd(32'h2000_0000, 16'd1501);
        repeat (5) @(negedge clk);
        wait_q(0, 2, 20);
        chk("t3_no_ar", DW'(ar_q.size()), DW'(0));
        s = pop_sts();
        chk("t3_sts63_error", DW'(s), DW'(1));
        s = pop_sts();
        chk("t3_sts1501_error", DW'(s), DW'(1));

        // Back-pressure: second burst waits for FIFO space
        tready_en = 1'b0;
        seen0     = n_axis_seen;
        send_cmd(32'h2100_0000, 16'd1500);
        send_cmd(32'h2200_0000, 16'd1500);
        repeat (40) @(negedge clk);
        chk("t4_arvalid_held", DW'(m_axi_arvalid), DW'(0));
        chk("t4_ar_count_held", DW'(ar_q.size()), DW'(1));
        chk("t4_no_axis", DW'(axis_q.size()), DW'(0));
        tready_en = 1'b1;
        wait_q(48, 2, 500);
        a  = pop_ar();
        a2 = pop_ar();
        chk("t4_ar1_addr", DW'(a.addr), DW'(32'h2100_0000));
        chk("t4_ar2_addr", DW'(a2.addr), DW'(32'h2200_0000));
        chk("t4_ar2_after_drain", DW'((a2.seen - seen0) >= 15), DW'(1));
        for (i = 0; i < 48; i++) begin
            b = pop_axis();
            chk("t4_tdata", b.data,
                exp_data((i < 24) ? 32'h2100_0000 : 32'h2200_0000, i % 24));
            chk("t4_tlast", DW'(b.last), DW'((i % 24) == 23));
        end
        s = pop_sts();
        chk("t4_sts1_error", DW'(s), DW'(0));
        s = pop_sts();
        chk("t4_sts2_error", DW'(s), DW'(0));

        // SLVERR on beat 3 of 4; unaligned address is forced to 64-byte boundary
        err_beat = 2;
        send_cmd(32'h3000_0005, 16'd256);
        wait_q(4, 1, 100);
        err_beat = -1;
        a = pop_ar();
        chk("t5_araddr", DW'(a.addr), DW'(32'h3000_0000));
        chk("t5_arlen",  DW'(a.len), DW'(3));
        for (i = 0; i < 4; i++) begin
            b = pop_axis();
            chk("t5_tdata", b.data, exp_data(32'h3000_0000, i));
            chk("t5_tlast", DW'(b.last), DW'(i == 3));
            chk("t5_tuser", DW'(b.user), DW'(i == 3));
            chk("t5_tkeep", DW'(b.keep), DW'(KEEP_ALL));
        end
        s = pop_sts();
        chk("t5_sts_error", DW'(s), DW'(1));

        // Reset in the middle of a burst
        tready_en = 1'b0;
        send_cmd(32'h4000_0000, 16'd1500);
        i = 0;
        while (!m_axi_rready && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("t6_reached_data", DW'(m_axi_rready), DW'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_cmd_ready", DW'(cmd_ready), DW'(0));
        chk("t6_arvalid",   DW'(m_axi_arvalid), DW'(0));
        chk("t6_rready",    DW'(m_axi_rready), DW'(0));
        chk("t6_tvalid",    DW'(m_axis_tvalid), DW'(0));
        chk("t6_tkeep",     DW'(m_axis_tkeep), DW'(0));
        chk("t6_tlast",     DW'(m_axis_tlast), DW'(0));
        chk("t6_sts_valid", DW'(sts_valid), DW'(0));
        chk("t6_araddr",    DW'(m_axi_araddr), DW'(0));
        repeat (2) @(negedge clk);
        axis_q.delete();
        sts_q.delete();
        ar_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tready_en = 1'b1;
        send_cmd(32'h5000_0000, 16'd128);
        wait_q(2, 1, 100);
        a = pop_ar();
        chk("t6_new_araddr", DW'(a.addr), DW'(32'h5000_0000));
        chk("t6_new_arlen",  DW'(a.len), DW'(1));
        for (i = 0; i < 2; i++) begin
            b = pop_axis();
            chk("t6_tdata", b.data, exp_data(32'h5000_0000, i));
            chk("t6_tlast_beat", DW'(b.last), DW'(i == 1));
            chk("t6_tkeep_beat", DW'(b.keep), DW'(KEEP_ALL));
            chk("t6_tuser_beat", DW'(b.user), DW'(0));
        end
        s = pop_sts();
        chk("t6_sts_error", DW'(s), DW'(0));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
